req_arbiter8: RTL

- 8-requester arbiter that shares one resource, such as a bus or a datapath port, between up to eight clients.
- Built around the team's 8-input priority-encode function.
- Registered one-hot grant, held while the owner keeps requesting.
- Selectable fixed-priority or round-robin policy; hold-time limit forces preemption so no client starves the others.

---
 rtl/req_arbiter8.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/req_arbiter8.sv
// rtl/req_arbiter8.sv - 8-requester arbiter, fixed-priority or round-robin, with hold-time preemption
module req_arbiter8 #(
    parameter int RR       = 0,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_n;
    logic [2:0]    rr_ptr;
    logic [2:0]    ptr_n;
    logic [7:0]    gnt_n;
    logic [2:0]    id_n;
    logic          valid_n;
    logic          preempt_n;

    logic [7:0]    others;
    logic [7:0]    cand;
    logic          owner_req;
    logic          win_valid;
    logic [2:0]    win_idx;

    // Returns {found, index of lowest set bit}.
    function automatic logic [3:0] prio_enc8(input logic [7:0] v);
        logic [3:0] r;
        r = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // gnt is one-hot, so masking with it isolates the owner without decoding gnt_id.
    assign owner_req = |(req & gnt);
    assign others    = req & ~gnt;
    assign cand      = (state == GRANT) ? others : req;

    generate
        if (RR != 0) begin : g_rr
            logic [7:0] rot;
            logic [3:0] enc;
            // Rotate so rr_ptr lands on bit 0, encode, then rotate the index back.
            always_comb begin
                rot       = 8'({cand, cand} >> rr_ptr);
                enc       = prio_enc8(rot);
                win_valid = enc[3];
                win_idx   = enc[2:0] + rr_ptr;
            end
        end else begin : g_fixed
            logic [3:0] enc;
            always_comb begin
                enc       = prio_enc8(cand);
                win_valid = enc[3];
                win_idx   = enc[2:0];
            end
        end
    endgenerate

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        ptr_n     = rr_ptr;
        gnt_n     = gnt;
        id_n      = gnt_id;
        valid_n   = gnt_valid;
        preempt_n = 1'b0;

        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_n = GRANT;
                    gnt_n   = 8'b1 << win_idx;
                    id_n    = win_idx;
                    valid_n = 1'b1;
                    hold_n  = '0;
                    ptr_n   = win_idx + 3'd1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    hold_n = '0;
                    if (win_valid) begin
                        gnt_n   = 8'b1 << win_idx;
                        id_n    = win_idx;
                        valid_n = 1'b1;
                        ptr_n   = win_idx + 3'd1;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 8'h00;
                        id_n    = 3'd0;
                        valid_n = 1'b0;
                    end
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_n = hold_cnt + HW'(1);
                end else if (win_valid) begin
                    // Hold expired with others waiting: force the grant over.
                    gnt_n     = 8'b1 << win_idx;
                    id_n      = win_idx;
                    valid_n   = 1'b1;
                    ptr_n     = win_idx + 3'd1;
                    hold_n    = '0;
                    preempt_n = 1'b1;
                end else begin
                    hold_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 8'h00;
                id_n    = 3'd0;
                valid_n = 1'b0;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rr_ptr    <= 3'd0;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            rr_ptr    <= ptr_n;
            gnt       <= gnt_n;
            gnt_id    <= id_n;
            gnt_valid <= valid_n;
            preempt   <= preempt_n;
        end
    end

endmodule
